// File: rtl/line_replay_buffer_pkg.sv
// -----------------------------------------------------------------------------
// line_replay_pkg
//   Shared definitions for the line replay buffer and its neighbours.
//   - state_t           : buffer FSM states (fill, stream, wait, decide)
//   - *_DEF constants   : default line geometry; the zoom stage uses the same
//                         LINE_WIDTH / PIXEL_W
//   - rep_width()       : width of the replay counter for a given MAX_REPEAT
// -----------------------------------------------------------------------------
package line_replay_pkg;

    localparam int LINE_WIDTH_DEF = 160;
    localparam int PIXEL_W_DEF    = 8;
    localparam int ADDR_W_DEF     = 8;
    localparam int MAX_REPEAT_DEF = 1;

    typedef enum logic [1:0] {
        ST_FILL   = 2'd0,
        ST_STREAM = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DECIDE = 2'd3
    } state_t;

    // clog2(MAX_REPEAT+1), kept at least 1 bit so MAX_REPEAT=0 still elaborates.
    function automatic int rep_width(input int max_repeat);
        return (max_repeat > 0) ? $clog2(max_repeat + 1) : 1;
    endfunction

endpackage

// File: rtl/line_replay_buffer_if.sv
// -----------------------------------------------------------------------------
// line_replay_buffer_if
//   Groups the source handshake, the zoom-stage pacing/repeat inputs and the
//   pixel stream outputs of line_replay_buffer.
//   slave  : buffer view (inputs src_pixel/src_valid/out_en/replay_req,
//            outputs src_ready/pixel_out/pixel_valid_out/line_end_out/busy)
//   master : environment view (opposite directions)
//   Optional: LINE_REPLAY_ERR_EN adds err_overflow (buffer output).
// -----------------------------------------------------------------------------
interface line_replay_buffer_if
    import line_replay_pkg::*;
#(
    parameter int PIXEL_W = PIXEL_W_DEF
);
    logic [PIXEL_W-1:0] src_pixel;
    logic               src_valid;
    logic               src_ready;
    logic               out_en;
    logic               replay_req;
    logic [PIXEL_W-1:0] pixel_out;
    logic               pixel_valid_out;
    logic               line_end_out;
    logic               busy;
`ifdef LINE_REPLAY_ERR_EN
    logic               err_overflow;
`endif

    modport slave (
        input  src_pixel, src_valid, out_en, replay_req,
        output src_ready, pixel_out, pixel_valid_out, line_end_out, busy
`ifdef LINE_REPLAY_ERR_EN
        , output err_overflow
`endif
    );

    modport master (
        output src_pixel, src_valid, out_en, replay_req,
        input  src_ready, pixel_out, pixel_valid_out, line_end_out, busy
`ifdef LINE_REPLAY_ERR_EN
        , input err_overflow
`endif
    );

endinterface

// File: rtl/line_replay_buffer_line_ram.sv
// -----------------------------------------------------------------------------
// line_ram
//   Single-port synchronous RAM holding one image line, registered read.
//   clk, rst : clock; async active-high reset (read register only)
//   i_we     : write i_wdata to mem[i_addr]
//   i_re     : read mem[i_addr] into o_rdata (valid the next cycle)
//   i_addr   : shared read/write address
//   o_rdata  : registered read data, holds between reads
// -----------------------------------------------------------------------------
module line_ram #(
    parameter int DEPTH  = 160,
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata;

    // NOTE: the storage array has no reset so it maps onto RAM macros; only the
    // read register is reset, which keeps pixel_out defined out of reset.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/line_replay_buffer.sv
// -----------------------------------------------------------------------------
// line_replay_buffer
//   Captures one line of LINE_WIDTH pixels from the frame-memory reader, then
//   streams it to the nearest-neighbour zoom stage. After each pass the zoom
//   stage may ask for the same line again (replay_req), up to MAX_REPEAT times
//   in a row, before the buffer refills. Single bank: fill and stream alternate.
//   clk, rst        : clock; async active-high reset
//   bus (slave)     : src_pixel/src_valid/src_ready  - fill handshake
//                     out_en                         - read pacing
//                     replay_req                     - repeat request
//                     pixel_out/pixel_valid_out/line_end_out - stream (latency 1)
//                     busy - not idle (idle = FILL at address 0)
//   Optional macro LINE_REPLAY_ERR_EN: adds sticky bus.err_overflow, set when
//   the source offers data while the buffer is not filling.
//   Requires LINE_WIDTH >= 2 and 2**ADDR_W >= LINE_WIDTH.
// -----------------------------------------------------------------------------
module line_replay_buffer
    import line_replay_pkg::*;
#(
    parameter int LINE_WIDTH = LINE_WIDTH_DEF,
    parameter int PIXEL_W    = PIXEL_W_DEF,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int MAX_REPEAT = MAX_REPEAT_DEF
) (
    input logic                clk,
    input logic                rst,
    line_replay_buffer_if.slave bus
);

    localparam int                REP_W     = rep_width(MAX_REPEAT);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(LINE_WIDTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [REP_W-1:0]  REP_MAX   = REP_W'(MAX_REPEAT);
    localparam logic [REP_W-1:0]  REP_ONE   = REP_W'(1);

    state_t             r_state;
    logic [ADDR_W-1:0]  r_wr_addr;
    logic [ADDR_W-1:0]  r_rd_addr;
    logic [REP_W-1:0]   r_rep_cnt;
    logic               r_pixel_valid;
    logic               r_line_end;

    logic               w_src_ready;
    logic               w_write;
    logic               w_read;
    logic [ADDR_W-1:0]  w_ram_addr;
    logic [PIXEL_W-1:0] w_ram_rdata;

    // Ready is a decode of the state, forced low while reset is asserted so
    // the source never sees a handshake during reset.
    assign w_src_ready = (r_state == ST_FILL) && !rst;
    assign w_write     = (r_state == ST_FILL) && bus.src_valid;
    assign w_read      = (r_state == ST_STREAM) && bus.out_en;
    assign w_ram_addr  = (r_state == ST_FILL) ? r_wr_addr : r_rd_addr;

    line_ram #(
        .DEPTH  (LINE_WIDTH),
        .DATA_W (PIXEL_W),
        .ADDR_W (ADDR_W)
    ) u_line_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_write),
        .i_re    (w_read),
        .i_addr  (w_ram_addr),
        .i_wdata (bus.src_pixel),
        .o_rdata (w_ram_rdata)
    );

    // NOTE: all state here is sequential and uses non-blocking assignments so
    // every register sees the pre-edge value of every other register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_FILL;
            r_wr_addr     <= '0;
            r_rd_addr     <= '0;
            r_rep_cnt     <= '0;
            r_pixel_valid <= 1'b0;
            r_line_end    <= 1'b0;
        end else begin
            // Flags are registered with the RAM read so they line up with the
            // read data one cycle later; no read means no valid pixel.
            r_pixel_valid <= w_read;
            r_line_end    <= w_read && (r_rd_addr == LAST_ADDR);

            case (r_state)
                ST_FILL: begin
                    if (bus.src_valid) begin
                        if (r_wr_addr == LAST_ADDR) begin
                            r_wr_addr <= '0;
                            r_state   <= ST_STREAM;
                        end else begin
                            r_wr_addr <= r_wr_addr + ADDR_ONE;
                        end
                    end
                end

                ST_STREAM: begin
                    if (bus.out_en) begin
                        if (r_rd_addr == LAST_ADDR) begin
                            r_rd_addr <= '0;
                            r_state   <= ST_WAIT;
                        end else begin
                            r_rd_addr <= r_rd_addr + ADDR_ONE;
                        end
                    end
                end

                // Last pixel is on the outputs now; the zoom stage registers
                // its repeat flag on this edge.
                ST_WAIT: begin
                    r_state <= ST_DECIDE;
                end

                ST_DECIDE: begin
                    if (bus.replay_req && (r_rep_cnt < REP_MAX)) begin
                        r_rep_cnt <= r_rep_cnt + REP_ONE;
                        r_state   <= ST_STREAM;
                    end else begin
                        r_rep_cnt <= '0;
                        r_state   <= ST_FILL;
                    end
                end

                default: begin
                    r_state <= ST_FILL;
                end
            endcase
        end
    end

`ifdef LINE_REPLAY_ERR_EN
    logic r_err_overflow;

    // Sticky until reset: the source offered a pixel the buffer could not take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err_overflow <= 1'b0;
        end else if (bus.src_valid && !w_src_ready && (r_state != ST_FILL)) begin
            r_err_overflow <= 1'b1;
        end
    end

    assign bus.err_overflow = r_err_overflow;
`endif

    assign bus.src_ready       = w_src_ready;
    assign bus.pixel_out       = w_ram_rdata;
    assign bus.pixel_valid_out = r_pixel_valid;
    assign bus.line_end_out    = r_line_end;
    assign bus.busy            = !((r_state == ST_FILL) && (r_wr_addr == '0));

endmodule

// File: tb/tb_line_replay_buffer.sv
// -----------------------------------------------------------------------------
// tb_line_replay_buffer
//   Directed bench for line_replay_buffer (default geometry 160 x 8 bit,
//   MAX_REPEAT=1). Inputs change 1 time unit after the rising edge; outputs
//   are observed at that same point, i.e. after the edge has settled.
//   With LINE_REPLAY_ERR_EN defined the err_overflow flag is checked as well.
// -----------------------------------------------------------------------------
module tb_line_replay_buffer;
    import line_replay_pkg::*;

    localparam int LW = LINE_WIDTH_DEF;
    localparam int PW = PIXEL_W_DEF;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    line_replay_buffer_if #(.PIXEL_W(PW)) bus ();

    line_replay_buffer #(
        .LINE_WIDTH (LW),
        .PIXEL_W    (PW),
        .ADDR_W     (ADDR_W_DEF),
        .MAX_REPEAT (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Writes base, base+1, ... (mod 256) with `gap` idle cycles before each word.
    task automatic fill_line(input logic [7:0] base, input int gap, input string name);
        int bad_ready = 0;
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_idle_busy got=%b want=0", name, bus.busy);
        end
        for (int i = 0; i < LW; i++) begin
            for (int g = 0; g < gap; g++) begin
                bus.src_valid = 1'b0;
                bus.src_pixel = 8'hEE;
                if (bus.src_ready !== 1'b1) bad_ready++;
                step();
            end
            if (bus.src_ready !== 1'b1) bad_ready++;
            bus.src_pixel = base + 8'(i);
            bus.src_valid = 1'b1;
            step();
        end
        bus.src_valid = 1'b0;
        checks++;
        if (bad_ready != 0) begin
            failures++;
            $display("FAIL %s_ready_during_fill low_cycles=%0d want=0", name, bad_ready);
        end
        checks++;
        if (bus.src_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_ready_drop got=%b want=0", name, bus.src_ready);
        end
        checks++;
        if (bus.busy !== 1'b1) begin
            failures++;
            $display("FAIL %s_busy_stream got=%b want=1", name, bus.busy);
        end
    endtask

    // Streams one pass, starting in STREAM. `toggle` paces out_en 1,0,1,0...
    // `junk` holds src_valid high with garbage data throughout.
    // `replay` is the replay_req value presented in DECIDE (it is held high
    // during STREAM/WAIT, where it must be ignored). `expect_fill` is the
    // state expected after DECIDE.
    task automatic stream_line(input logic [7:0] base, input bit toggle, input bit junk,
                               input bit replay, input bit expect_fill, input string name);
        int       n         = 0;
        int       issued    = 0;
        int       bad_valid = 0;
        int       bad_data  = 0;
        int       bad_end   = 0;
        bit       en;
        bit       issue_now;
        logic [7:0] exp_pix;

        bus.replay_req = 1'b1;
        bus.src_valid  = junk;
        bus.src_pixel  = 8'hEE;
        for (int cyc = 0; cyc < 4 * LW && n < LW; cyc++) begin
            en        = toggle ? (cyc % 2 == 0) : 1'b1;
            issue_now = en && (issued < LW);
            if (issue_now) issued++;
            bus.out_en = en;
            step();
            if (bus.pixel_valid_out !== issue_now) bad_valid++;
            if (bus.pixel_valid_out === 1'b1) begin
                exp_pix = base + 8'(n);
                if (bus.pixel_out !== exp_pix) begin
                    if (bad_data == 0)
                        $display("  first bad pixel idx=%0d got=%0d want=%0d", n, bus.pixel_out, exp_pix);
                    bad_data++;
                end
                if (bus.line_end_out !== (n == LW - 1)) bad_end++;
                n++;
            end else if (bus.line_end_out !== 1'b0) begin
                bad_end++;
            end
        end
        checks++;
        if (n != LW) begin
            failures++;
            $display("FAIL %s_pixel_count got=%0d want=%0d", name, n, LW);
        end
        checks++;
        if (bad_valid != 0) begin
            failures++;
            $display("FAIL %s_valid_timing bad=%0d want=0", name, bad_valid);
        end
        checks++;
        if (bad_data != 0) begin
            failures++;
            $display("FAIL %s_pixel_data bad=%0d want=0", name, bad_data);
        end
        checks++;
        if (bad_end != 0) begin
            failures++;
            $display("FAIL %s_line_end bad=%0d want=0", name, bad_end);
        end

        // WAIT cycle: last pixel on the outputs, replay_req still high.
        step();
        // DECIDE cycle: no pixel, no ready.
        checks++;
        if (bus.pixel_valid_out !== 1'b0 || bus.line_end_out !== 1'b0 || bus.src_ready !== 1'b0) begin
            failures++;
            $display("FAIL %s_decide_outputs got=v%b e%b r%b want=v0 e0 r0", name,
                     bus.pixel_valid_out, bus.line_end_out, bus.src_ready);
        end
        bus.replay_req = replay;
        step();
        checks++;
        if (bus.src_ready !== expect_fill) begin
            failures++;
            $display("FAIL %s_next_state src_ready got=%b want=%b", name, bus.src_ready, expect_fill);
        end
        checks++;
        if (bus.busy !== !expect_fill) begin
            failures++;
            $display("FAIL %s_next_busy got=%b want=%b", name, bus.busy, !expect_fill);
        end
        bus.replay_req = 1'b0;
        bus.src_valid  = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        bus.src_pixel  = '0;
        bus.src_valid  = 1'b0;
        bus.out_en     = 1'b0;
        bus.replay_req = 1'b0;
        step();
        step();
        checks++;
        if (bus.pixel_out !== 8'd0) begin
            failures++;
            $display("FAIL reset_pixel_out got=%0d want=0", bus.pixel_out);
        end
        checks++;
        if (bus.pixel_valid_out !== 1'b0 || bus.line_end_out !== 1'b0) begin
            failures++;
            $display("FAIL reset_flags got=v%b e%b want=v0 e0", bus.pixel_valid_out, bus.line_end_out);
        end
        checks++;
        if (bus.src_ready !== 1'b0) begin
            failures++;
            $display("FAIL reset_src_ready got=%b want=0", bus.src_ready);
        end
        checks++;
        if (bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_busy got=%b want=0", bus.busy);
        end
`ifdef LINE_REPLAY_ERR_EN
        checks++;
        if (bus.err_overflow !== 1'b0) begin
            failures++;
            $display("FAIL reset_err_overflow got=%b want=0", bus.err_overflow);
        end
`endif
        rst = 1'b0;
        #1;
        checks++;
        if (bus.src_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_release_ready got=%b want=1", bus.src_ready);
        end
        step();
    endtask

    task automatic test_basic();
        fill_line(8'd0, 0, "basic");
        stream_line(8'd0, 1'b0, 1'b0, 1'b0, 1'b1, "basic");
    endtask

    task automatic test_replay();
        fill_line(8'h40, 0, "replay");
        stream_line(8'h40, 1'b0, 1'b0, 1'b1, 1'b0, "replay_pass1");
        // replay_req held high again: MAX_REPEAT=1 forces a refill now.
        stream_line(8'h40, 1'b0, 1'b0, 1'b1, 1'b1, "replay_pass2");
    endtask

    task automatic test_out_en_toggle();
        fill_line(8'h80, 0, "toggle");
        stream_line(8'h80, 1'b1, 1'b1, 1'b0, 1'b1, "toggle");
`ifdef LINE_REPLAY_ERR_EN
        checks++;
        if (bus.err_overflow !== 1'b1) begin
            failures++;
            $display("FAIL err_overflow_set got=%b want=1", bus.err_overflow);
        end
        step();
        checks++;
        if (bus.err_overflow !== 1'b1) begin
            failures++;
            $display("FAIL err_overflow_sticky got=%b want=1", bus.err_overflow);
        end
`endif
    endtask

    task automatic test_fill_gaps();
        fill_line(8'h33, 2, "gaps");
        stream_line(8'h33, 1'b0, 1'b0, 1'b0, 1'b1, "gaps");
    endtask

    task automatic test_reset_midline();
        fill_line(8'd5, 0, "midrst");
        bus.out_en = 1'b1;
        for (int i = 0; i < 80; i++) step();
        checks++;
        if (bus.pixel_out !== 8'd84 || bus.pixel_valid_out !== 1'b1) begin
            failures++;
            $display("FAIL midrst_before got=%0d v%b want=84 v1", bus.pixel_out, bus.pixel_valid_out);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.pixel_out !== 8'd0 || bus.pixel_valid_out !== 1'b0 || bus.line_end_out !== 1'b0) begin
            failures++;
            $display("FAIL midrst_outputs got=%0d v%b e%b want=0 v0 e0", bus.pixel_out,
                     bus.pixel_valid_out, bus.line_end_out);
        end
        checks++;
        if (bus.src_ready !== 1'b0 || bus.busy !== 1'b0) begin
            failures++;
            $display("FAIL midrst_ready_busy got=r%b b%b want=r0 b0", bus.src_ready, bus.busy);
        end
`ifdef LINE_REPLAY_ERR_EN
        checks++;
        if (bus.err_overflow !== 1'b0) begin
            failures++;
            $display("FAIL err_overflow_clear got=%b want=0", bus.err_overflow);
        end
`endif
        rst        = 1'b0;
        bus.out_en = 1'b0;
        step();
        checks++;
        if (bus.src_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_fill_state got=%b want=1", bus.src_ready);
        end
        fill_line(8'd200, 0, "after_rst");
        stream_line(8'd200, 1'b0, 1'b0, 1'b0, 1'b1, "after_rst");
    endtask

    initial begin
        test_reset();
        test_basic();
        test_replay();
        test_out_en_toggle();
        test_fill_gaps();
        test_reset_midline();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/line_replay_buffer.md
Name: line_replay_buffer

Overview:
- Upstream neighbour of the nearest-neighbour zoom stage. Captures one image line of LINE_WIDTH pixels from the frame-memory reader.
- Streams the line out as pixel/valid/line-end toward the zoom stage.
- Replays the same line without refilling when the zoom stage requests vertical duplication through its repeat flag.
- Single-bank storage; fill and stream phases alternate.

Parameters:
- LINE_WIDTH, 160, pixels per line (≥2).
- PIXEL_W, 8, bits per pixel.
- ADDR_W, 8, address width; must satisfy 2^ADDR_W ≥ LINE_WIDTH.
- MAX_REPEAT, 1, maximum consecutive replays of one line before a forced refill.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-high.
- src_pixel  in  PIXEL_W  pixel from memory reader.
- src_valid  in  1  src_pixel valid.
- src_ready  out  1  buffer accepts src_pixel this cycle.
- out_en  in  1  downstream pacing; read issued only when high.
- replay_req  in  1  repeat request, driven by the zoom stage's repeat_line_buffer.
- pixel_out  out  PIXEL_W  pixel to zoom stage.
- pixel_valid_out  out  1  pixel_out valid.
- line_end_out  out  1  high together with the last pixel of the line.
- busy  out  1  high when the state is not FILL with wr_addr==0.

Behaviour:
- Reset values:
  - pixel_out=0, pixel_valid_out=0, line_end_out=0, src_ready=0.
  - State=FILL, wr_addr=0, rd_addr=0, rep_cnt=0.
  - Memory contents are undefined.
- FILL:
  - src_ready=1 (combinational from state).
  - Each src_valid cycle writes mem[wr_addr] and increments wr_addr.
  - On the write at LINE_WIDTH-1: wr_addr←0, go to STREAM.
- STREAM:
  - src_ready=0.
  - Each out_en cycle reads mem[rd_addr].
  - pixel_out and pixel_valid_out are registered, so they appear 1 cycle after the read (latency 1).
  - Cycles with out_en=0 issue no read; next cycle pixel_valid_out=0.
  - line_end_out is registered alongside the read of address LINE_WIDTH-1.
  - After that read: rd_addr←0, go to WAIT.
- WAIT:
  - One cycle, no read.
  - The last pixel is presented on this cycle.
  - Gives the zoom stage one edge to register its repeat flag.
- DECIDE:
  - One cycle; samples replay_req.
  - replay_req=1 and rep_cnt<MAX_REPEAT: rep_cnt++, go to STREAM.
  - Otherwise: rep_cnt←0, go to FILL.
- pixel_valid_out and line_end_out are 0 in FILL, WAIT (after the last pixel), and DECIDE.
- Boundaries:
  - src_valid while src_ready=0: data ignored; the source must hold it.
  - out_en low on the last read: line_end_out is deferred until the read actually happens.
  - replay_req is ignored outside DECIDE.
  - Reset asserted mid-line: the partial line is discarded and the block restarts in FILL at address 0.
- Width rules:
  - Address counters wrap by explicit compare to LINE_WIDTH-1, never by overflow.
  - rep_cnt width is clog2(MAX_REPEAT+1).

Optional Feature:
- Macro LINE_REPLAY_ERR_EN.
- When defined:
  - Adds output err_overflow (1 bit), reset 0.
  - It sets sticky when src_valid=1 while src_ready=0 and state≠FILL.
  - Cleared only by rst.
- When not defined:
  - The port and its logic are absent.
  - Dropped-handshake cases are silently ignored.

Decomposition:
- Package line_replay_pkg holds:
  - the state enum (FILL, STREAM, WAIT, DECIDE);
  - default LINE_WIDTH and PIXEL_W constants, shared with the zoom stage.
- One natural sub-module: line_ram, a single-port synchronous RAM of LINE_WIDTH×PIXEL_W with a registered read. The FSM and counters stay in the top module.

Test Plan:
- Fill 0..159 with src_valid continuous, out_en=1, replay_req=0:
  - src_ready drops after the 160th write.
  - pixel_out emits 0..159, starting 1 cycle after STREAM entry.
  - line_end_out only with 159.
  - Returns to FILL 2 cycles after the last read.
- Same fill, replay_req=1 in DECIDE: the line 0..159 streams twice, then the block refills. With MAX_REPEAT=1, replay_req held high still gives only 2 passes.
- out_en toggling 1,0,1,0 during STREAM:
  - pixel_valid_out follows out_en delayed 1 cycle.
  - No pixel is skipped or duplicated; line_end_out is still on pixel 159.
- src_valid gaps during FILL (valid every 3rd cycle): all 160 values are stored in order, and STREAM output matches.
- Assert rst while rd_addr=80:
  - All outputs are 0 the same cycle.
  - State is FILL; the next fill of values 200..(200+159 mod 256) streams correctly.
- With LINE_REPLAY_ERR_EN, hold src_valid=1 during STREAM: err_overflow rises to 1 and stays there until rst.
